// File: rtl/arbitro_multi.sv
// arbitro_multi: custom-instruction front end for a UART sensor bus.
// Takes {sensor address, command} from the processor. Sends both bytes through an
// external uart_tx. Assembles a RESP_BYTES-long reply from an external uart_rx and
// returns it with a 2-bit status.
//
// Ports:
//   clock, reset      system clock, asynchronous active-high reset
//   clock_en          start strobe, honoured only in IDLE
//   dataA             [15:8] sensor address, [7:0] command, [31:16] ignored
//   rx_DV, rx_byte    received-byte strobe and data from uart_rx
//   tx_done           uart_tx finished the current byte
//   tx_DV, tx_byte    transmit strobe and data to uart_tx
//   busy              high whenever the FSM is not idle
//   done, result      one-cycle completion pulse, {status[31:30], reply data}
module arbitro_multi #(
   parameter int unsigned N_SENSORS      = 32,
   parameter int unsigned RESP_BYTES     = 2,
   parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        clock_en,
   input  logic [31:0] dataA,
   input  logic        rx_DV,
   input  logic [7:0]  rx_byte,
   input  logic        tx_done,
   output logic        tx_DV,
   output logic [7:0]  tx_byte,
   output logic        busy,
   output logic        done,
   output logic [31:0] result
);

   localparam int unsigned DW = 8 * RESP_BYTES;
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0]    BYTES_LAST = 2'(RESP_BYTES);

   typedef enum logic [2:0] {
      StIdle, StSendAddr, StWaitAddr, StSendCmd, StWaitCmd, StRecv, StFinish
   } state_e;

   state_e         state_q, state_d;
   logic [7:0]     addr_q, cmd_q;
   logic [DW-1:0]  data_q;
   logic [1:0]     status_q;
   logic [1:0]     byte_cnt_q;
   logic [TW-1:0]  to_cnt_q;

   logic           tx_dv_q, tx_dv_d;
   logic [7:0]     tx_byte_q, tx_byte_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic [31:0]    result_q, result_d;

   logic           addr_bad, rx_last, to_expire;
   logic [TW-1:0]  to_next;

   logic unused_bits;
   assign unused_bits = ^dataA[31:16];

   assign addr_bad  = {24'b0, dataA[15:8]} >= N_SENSORS;
   assign rx_last   = (byte_cnt_q + 2'd1) == BYTES_LAST;
   assign to_next   = to_cnt_q + 1'b1;
   assign to_expire = to_next == TO_LAST;

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:     if (clock_en) state_d = addr_bad ? StFinish : StSendAddr;
         StSendAddr: state_d = StWaitAddr;
         StWaitAddr: if (tx_done) state_d = StSendCmd;
         StSendCmd:  state_d = StWaitCmd;
         StWaitCmd:  if (tx_done) state_d = StRecv;
         StRecv: begin
            // A byte arriving on the expiry cycle wins over the timeout.
            if (rx_DV) begin
               if (rx_last) state_d = StFinish;
            end else if (to_expire) begin
               state_d = StFinish;
            end
         end
         StFinish:   state_d = StIdle;
         default:    state_d = StIdle;
      endcase
   end

   // Output logic: next values of the registered outputs
   always_comb begin
      tx_dv_d   = (state_q == StSendAddr) || (state_q == StSendCmd);
      tx_byte_d = tx_byte_q;
      if (state_q == StSendAddr) tx_byte_d = addr_q;
      if (state_q == StSendCmd)  tx_byte_d = cmd_q;
      busy_d    = state_d != StIdle;
      done_d    = state_q == StFinish;
      result_d  = result_q;
      if (state_q == StFinish) result_d = {status_q, {(30 - DW){1'b0}}, data_q};
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tx_dv_q   <= 1'b0;
         tx_byte_q <= 8'h00;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         result_q  <= 32'h0;
      end else begin
         tx_dv_q   <= tx_dv_d;
         tx_byte_q <= tx_byte_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         result_q  <= result_d;
      end
   end

   // Request latch, reply assembly and counters
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         addr_q     <= 8'h00;
         cmd_q      <= 8'h00;
         data_q     <= '0;
         status_q   <= 2'b00;
         byte_cnt_q <= 2'd0;
         to_cnt_q   <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (clock_en) begin
                  addr_q   <= dataA[15:8];
                  cmd_q    <= dataA[7:0];
                  data_q   <= '0;
                  status_q <= addr_bad ? 2'b10 : 2'b00;
               end
            end
            StWaitCmd: begin
               if (tx_done) begin
                  byte_cnt_q <= 2'd0;
                  to_cnt_q   <= '0;
               end
            end
            StRecv: begin
               if (rx_DV) begin
                  data_q     <= (data_q << 8) | DW'(rx_byte);
                  byte_cnt_q <= byte_cnt_q + 2'd1;
                  to_cnt_q   <= '0;
               end else if (to_expire) begin
                  status_q <= 2'b01;
                  data_q   <= '0;
               end else begin
                  to_cnt_q <= to_next;
               end
            end
            default: ;
         endcase
      end
   end

   assign tx_DV   = tx_dv_q;
   assign tx_byte = tx_byte_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign result  = result_q;

endmodule
